// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mem_port_arbiter                                              |
// | Purpose  : Shares one memory/L2 port between the instruction port (A,    |
// |            read-only) and the data port (B, read/write). The granted     |
// |            request is latched and held stable downstream until mem_resp, |
// |            and the completion is routed only to the granted requester.   |
// | Ports    : clk, reset_n (sync, active-low)                               |
// |            A : read_a, address_a -> resp_a, rdata_a                      |
// |            B : read_b, write_b, wmask_b, address_b, wdata_b              |
// |                -> resp_b, rdata_b                                        |
// |            mem : mem_read, mem_write, mem_wmask, mem_address, mem_wdata  |
// |                  <- mem_resp, mem_rdata                                  |
// | Options  : ROUND_ROBIN_EN - alternate grants on ties (default: B wins).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  // port A (instruction, read-only)
  input  logic                read_a,
  input  logic [ADDR_W-1:0]   address_a,
  output logic                resp_a,
  output logic [DATA_W-1:0]   rdata_a,
  // port B (data, read/write)
  input  logic                read_b,
  input  logic                write_b,
  input  logic [DATA_W/8-1:0] wmask_b,
  input  logic [ADDR_W-1:0]   address_b,
  input  logic [DATA_W-1:0]   wdata_b,
  output logic                resp_b,
  output logic [DATA_W-1:0]   rdata_b,
  // downstream memory port
  output logic                mem_read,
  output logic                mem_write,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_resp,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int c_MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SERVE_A = 2'd1,
    S_SERVE_B = 2'd2,
    S_TURN    = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  // holding registers: the only source of the downstream request
  logic [ADDR_W-1:0]     r_addr;
  logic [DATA_W-1:0]     r_wdata;
  logic [c_MASK_W-1:0]   r_wmask;
  logic                  r_is_write;

  logic                  w_req_a;
  logic                  w_req_b;
  logic                  w_grant_a;
  logic                  w_grant_b;
  logic                  w_idle;

  assign w_req_a = read_a;
  assign w_req_b = read_b | write_b;
  assign w_idle  = (r_state == S_IDLE);

`ifdef ROUND_ROBIN_EN
  // r_last_b = 1 when B received the most recent grant; reset state means "A".
  logic r_last_b;

  // On a tie, the port that was not granted last wins.
  assign w_grant_b = w_req_b & (~w_req_a | ~r_last_b);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_last_b <= 1'b0;
    end else if (w_idle && (w_grant_a || w_grant_b)) begin
      r_last_b <= w_grant_b;
    end
  end
`else
  // Fixed priority: any pending B request beats A.
  assign w_grant_b = w_req_b;
`endif

  assign w_grant_a = w_req_a & ~w_grant_b;

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. TURN burns one cycle so a requester that has just been
  // answered can drop or replace its request before the next arbitration.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_b) begin
          w_state_nxt = S_SERVE_B;
        end else if (w_grant_a) begin
          w_state_nxt = S_SERVE_A;
        end
      end
      S_SERVE_A, S_SERVE_B: begin
        if (mem_resp) begin
          w_state_nxt = S_TURN;
        end
      end
      S_TURN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Capture the winning request at grant time. A read+write on B is a write.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_is_write <= 1'b0;
    end else if (w_idle) begin
      if (w_grant_b) begin
        r_addr     <= address_b;
        r_wdata    <= wdata_b;
        r_wmask    <= wmask_b;
        r_is_write <= write_b;
      end else if (w_grant_a) begin
        r_addr     <= address_a;
        r_wdata    <= '0;
        r_wmask    <= '0;
        r_is_write <= 1'b0;
      end
    end
  end

  logic w_serve_a;
  logic w_serve_b;

  assign w_serve_a = (r_state == S_SERVE_A);
  assign w_serve_b = (r_state == S_SERVE_B);

  // Downstream request is zero outside SERVE so reset/idle present a quiet bus.
  assign mem_read    = w_serve_a | (w_serve_b & ~r_is_write);
  assign mem_write   = w_serve_b & r_is_write;
  assign mem_address = (w_serve_a | w_serve_b) ? r_addr : '0;
  assign mem_wdata   = mem_write ? r_wdata : '0;
  assign mem_wmask   = mem_write ? r_wmask : '0;

  // Completion is steered by state, so a stray mem_resp in IDLE/TURN is dropped.
  assign resp_a  = w_serve_a & mem_resp;
  assign resp_b  = w_serve_b & mem_resp;
  assign rdata_a = mem_rdata;
  assign rdata_b = mem_rdata;

endmodule
`default_nettype wire
